// File: rtl/conv3x3_window_reader.sv
// Streams a 32x32 tile out of a ping-pong buffer as 3x3 windows (9 reads per output)
// and produces one signed 20-bit valid-convolution result per window, row-major.
module conv3x3_window_reader (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_buffer_ready,
    output logic [9:0]  o_conv_addr,
    input  logic [7:0]  i_conv_dout,
    input  logic [71:0] i_weights,
    output logic [19:0] o_psum,
    output logic        o_psum_vld,
    output logic        o_switch_pingpong,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [4:0] LAST_POS = 5'd29;
    localparam logic [9:0] LAST_OUT = 10'd899;

    logic [1:0]  state_q, state_d;
    logic [4:0]  row_q, row_d, col_q, col_d;
    logic [1:0]  ky_q, ky_d, kx_q, kx_d;
    logic        hold_q, hold_d;
    logic [9:0]  out_cnt_q, out_cnt_d;
    logic [71:0] weights_q;

    logic        p1_vld_q;
    logic [3:0]  p1_tap_q;
    logic        p2_last_q;
    logic signed [19:0] acc_q;
    logic [19:0] psum_q;
    logic        psum_vld_q, switch_q, done_q;

    logic        fetch, last_fetch, last_out;
    logic [4:0]  row_a, col_a;
    logic [3:0]  tap;
    logic [7:0]  w_sel;
    logic signed [16:0] prod;
    logic signed [19:0] prod_ext;

    assign fetch      = (state_q == S_FETCH);
    assign last_fetch = fetch && (row_q == LAST_POS) && (col_q == LAST_POS)
                        && (ky_q == 2'd2) && (kx_q == 2'd2);
    assign last_out   = p2_last_q && (out_cnt_q == LAST_OUT);

    // Window origin plus tap offset; col never exceeds 31 so the
    // row*32+col address is a plain concatenation.
    assign row_a = row_q + {3'b000, ky_q};
    assign col_a = col_q + {3'b000, kx_q};
    assign tap   = ({2'b00, ky_q} * 4'd3) + {2'b00, kx_q};

    assign o_conv_addr = fetch ? {row_a, col_a} : 10'd0;
    assign o_busy      = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        ky_d      = ky_q;
        kx_d      = kx_q;
        hold_d    = hold_q;
        out_cnt_d = p2_last_q ? ((out_cnt_q == LAST_OUT) ? 10'd0 : out_cnt_q + 10'd1) : out_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_buffer_ready) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (kx_q != 2'd2) begin
                    kx_d = kx_q + 2'd1;
                end else begin
                    kx_d = 2'd0;
                    if (ky_q != 2'd2) begin
                        ky_d = ky_q + 2'd1;
                    end else begin
                        ky_d = 2'd0;
                        if (col_q != LAST_POS) begin
                            col_d = col_q + 5'd1;
                        end else begin
                            col_d = 5'd0;
                            row_d = (row_q == LAST_POS) ? 5'd0 : row_q + 5'd1;
                        end
                    end
                end
                if (last_fetch) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (last_out) begin
                    state_d = S_HOLD;
                    hold_d  = 1'b0;
                end
            end
            default: begin
                hold_d = ~hold_q;
                if (hold_q) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            row_q     <= 5'd0;
            col_q     <= 5'd0;
            ky_q      <= 2'd0;
            kx_q      <= 2'd0;
            hold_q    <= 1'b0;
            out_cnt_q <= 10'd0;
            weights_q <= 72'd0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            ky_q      <= ky_d;
            kx_q      <= kx_d;
            hold_q    <= hold_d;
            out_cnt_q <= out_cnt_d;
            if (state_q == S_IDLE && i_buffer_ready) weights_q <= i_weights;
        end
    end

    // Pixel arrives one cycle after its address, so the tap index rides one stage behind.
    assign w_sel    = weights_q[{p1_tap_q, 3'b000} +: 8];
    assign prod     = $signed({9'd0, i_conv_dout}) * $signed({{9{w_sel[7]}}, w_sel});
    assign prod_ext = {{3{prod[16]}}, prod};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            p1_vld_q   <= 1'b0;
            p1_tap_q   <= 4'd0;
            p2_last_q  <= 1'b0;
            acc_q      <= 20'sd0;
            psum_q     <= 20'd0;
            psum_vld_q <= 1'b0;
            switch_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            p1_vld_q  <= fetch;
            p1_tap_q  <= tap;
            p2_last_q <= p1_vld_q && (p1_tap_q == 4'd8);
            if (p1_vld_q) acc_q <= (p1_tap_q == 4'd0) ? prod_ext : acc_q + prod_ext;
            psum_vld_q <= p2_last_q;
            if (p2_last_q) psum_q <= acc_q;
            done_q <= last_out;
            if (last_out) switch_q <= ~switch_q;
        end
    end

    assign o_psum            = psum_q;
    assign o_psum_vld        = psum_vld_q;
    assign o_switch_pingpong = switch_q;
    assign o_done            = done_q;

endmodule
